tinyfpga_fabric: RTL

Parametrised programmable logic array: NUM_LUT K-input LUTs with per-LUT optional flip-flop, input crossbar and registered feedback, configured through a serial bit chain. Instantiated inside the TinyTapeout top wrapper. ui_in/uio_in drive fab_in, fab_out drives uo_out, and config pins come from dedicated inputs. Replaces the fixed-function datapath with user-loadable logic.

---
 rtl/tinyfpga_pkg.sv | 35 +++
 rtl/tinyfpga_lut_cell.sv | 56 +++++
 rtl/tinyfpga_fabric.sv | 109 ++++++++++
 3 files changed

// File: rtl/tinyfpga_pkg.sv
// rtl/tinyfpga_pkg.sv - shared types and config-layout helpers for the LUT fabric
package tinyfpga_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    LOAD = 2'd1,
    RUN  = 2'd2
  } state_e;

  localparam int TRUTH_OFF = 0;

  function automatic int clog2(input int v);
    int r;
    for (r = 0; (1 << r) < v; r++) begin
    end
    return r;
  endfunction

  function automatic int lut_bits(input int k, input int sel_w);
    return (2 ** k) + k * sel_w + 1;
  endfunction

  function automatic int cfg_bits(input int n_lut, input int k, input int sel_w);
    return n_lut * lut_bits(k, sel_w);
  endfunction

  function automatic int sel_off(input int k, input int idx, input int sel_w);
    return (2 ** k) + idx * sel_w;
  endfunction

  function automatic int reg_off(input int k, input int sel_w);
    return lut_bits(k, sel_w) - 1;
  endfunction

endpackage

// File: rtl/tinyfpga_lut_cell.sv
// rtl/tinyfpga_lut_cell.sv - one K-input LUT with input crossbar and optional output flop
module tinyfpga_lut_cell
  import tinyfpga_pkg::*;
#(
  parameter int NUM_IN   = 16,
  parameter int NUM_LUT  = 8,
  parameter int LUT_K    = 4,
  parameter int SEL_W    = 5,
  parameter int LUT_BITS = 37
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                run,
  input  logic                ff_run,
  input  logic [LUT_BITS-1:0] cfg,
  input  logic [NUM_IN-1:0]   fab_in,
  input  logic [NUM_LUT-1:0]  ff_vec,
  output logic                ff_o,
  output logic                cell_out
);

  logic [2**LUT_K-1:0] truth;
  logic [LUT_K-1:0]    addr;
  logic [SEL_W-1:0]    sel;
  logic                lut_out;
  logic                reg_en;
  logic                ff_d;
  logic                ff_q;

  assign truth  = cfg[TRUTH_OFF +: 2**LUT_K];
  assign reg_en = cfg[reg_off(LUT_K, SEL_W)];

  // Unmatched select codes leave the address bit at 0.
  always_comb begin
    addr = '0;
    sel  = '0;
    for (int k = 0; k < LUT_K; k++) begin
      sel = cfg[sel_off(LUT_K, k, SEL_W) +: SEL_W];
      for (int i = 0; i < NUM_IN; i++)
        if (sel == SEL_W'(i)) addr[k] = fab_in[i];
      for (int i = 0; i < NUM_LUT; i++)
        if (sel == SEL_W'(NUM_IN + i)) addr[k] = ff_vec[i];
    end
    lut_out  = truth[addr];
    ff_d     = ff_run & lut_out;
    cell_out = run & (reg_en ? ff_q : lut_out);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) ff_q <= 1'b0;
    else        ff_q <= ff_d;
  end

  assign ff_o = ff_q;

endmodule

// File: rtl/tinyfpga_fabric.sv
// rtl/tinyfpga_fabric.sv - serially configured LUT fabric with registered feedback
module tinyfpga_fabric
  import tinyfpga_pkg::*;
#(
  parameter int NUM_IN  = 16,
  parameter int NUM_LUT = 8,
  parameter int LUT_K   = 4
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               cfg_en,
  input  logic               cfg_data,
  output logic               cfg_out,
  output logic               cfg_done,
  output logic               cfg_err,
  input  logic [NUM_IN-1:0]  fab_in,
  output logic [NUM_LUT-1:0] fab_out
);

  localparam int SEL_W    = clog2(NUM_IN + NUM_LUT);
  localparam int LUT_BITS = lut_bits(LUT_K, SEL_W);
  localparam int CFG_BITS = cfg_bits(NUM_LUT, LUT_K, SEL_W);
  localparam int CNT_W    = clog2(CFG_BITS + 2);

  state_e              state_q, state_d;
  logic [CNT_W-1:0]    cnt_q, cnt_d;
  logic                err_q, err_d;
  logic [CFG_BITS-1:0] chain_q, chain_d;
  logic                cfg_out_q, cfg_out_d;
  logic [NUM_LUT-1:0]  ff_vec;
  logic                run;
  logic                ff_run;

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    err_d     = err_q;
    chain_d   = chain_q;
    cfg_out_d = cfg_out_q;
    if (cfg_en) begin
      chain_d   = {chain_q[CFG_BITS-2:0], cfg_data};
      cfg_out_d = chain_q[CFG_BITS-1];
    end
    case (state_q)
      LOAD: begin
        if (cfg_en) begin
          if (cnt_q != CNT_W'(CFG_BITS + 1)) cnt_d = cnt_q + CNT_W'(1);
        end else if (cnt_q == CNT_W'(CFG_BITS)) begin
          state_d = RUN;
        end else begin
          state_d = IDLE;
          err_d   = 1'b1;
        end
      end
      default: begin
        if (cfg_en) begin
          state_d = LOAD;
          cnt_d   = CNT_W'(1);
          err_d   = 1'b0;
        end
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      cnt_q     <= '0;
      err_q     <= 1'b0;
      chain_q   <= '0;
      cfg_out_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      err_q     <= err_d;
      chain_q   <= chain_d;
      cfg_out_q <= cfg_out_d;
    end
  end

  // Flops clear on the same edge that leaves RUN for a reload.
  assign run    = (state_q == RUN);
  assign ff_run = run & ~cfg_en;

  for (genvar j = 0; j < NUM_LUT; j++) begin : g_cell
    tinyfpga_lut_cell #(
      .NUM_IN  (NUM_IN),
      .NUM_LUT (NUM_LUT),
      .LUT_K   (LUT_K),
      .SEL_W   (SEL_W),
      .LUT_BITS(LUT_BITS)
    ) u_cell (
      .clk     (clk),
      .rst_n   (rst_n),
      .run     (run),
      .ff_run  (ff_run),
      .cfg     (chain_q[j*LUT_BITS +: LUT_BITS]),
      .fab_in  (fab_in),
      .ff_vec  (ff_vec),
      .ff_o    (ff_vec[j]),
      .cell_out(fab_out[j])
    );
  end

  assign cfg_out  = cfg_out_q;
  assign cfg_done = run;
  assign cfg_err  = err_q;

endmodule
